// File: rtl/majority_vote_sync.sv
// Registered N-channel bitwise majority voter with sticky per-channel fault flags.
// Latency 1 cycle, accepts a sample every cycle; no backpressure (valid_in only).
module majority_vote_sync #(
    parameter int N_CH        = 3,
    parameter int WIDTH       = 8,
    parameter int FAULT_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*WIDTH-1:0]  x,
    input  logic                   valid_in,
    input  logic                   clear_faults,
    output logic [WIDTH-1:0]       y,
    output logic                   y_valid,
    output logic [N_CH-1:0]        disagree,
    output logic [N_CH-1:0]        faulty,
    output logic                   any_fault
);

    localparam int CW = $clog2(FAULT_LIMIT + 1);
    localparam int OW = $clog2(N_CH + 1);
    localparam logic [CW-1:0] LIMIT = CW'(FAULT_LIMIT);
    localparam logic [OW-1:0] HALF  = OW'(N_CH / 2);

    generate
        if ((N_CH < 3) || ((N_CH % 2) == 0)) begin : g_bad_nch
            $error("majority_vote_sync: N_CH must be odd and >= 3");
        end
        if (FAULT_LIMIT < 1) begin : g_bad_limit
            $error("majority_vote_sync: FAULT_LIMIT must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] voted;
    logic [OW-1:0]    ones;
    logic [N_CH-1:0]  diff_now;
    logic [CW-1:0]    cnt     [N_CH];
    logic [CW-1:0]    cnt_nxt [N_CH];
    logic [N_CH-1:0]  faulty_nxt;

    // Odd channel count means a strict majority always exists per bit.
    always_comb begin
        voted = '0;
        ones  = '0;
        for (int b = 0; b < WIDTH; b++) begin
            ones = '0;
            for (int k = 0; k < N_CH; k++) begin
                ones = ones + OW'(x[k*WIDTH + b]);
            end
            voted[b] = (ones > HALF);
        end
    end

    always_comb begin
        diff_now   = '0;
        faulty_nxt = faulty;
        for (int k = 0; k < N_CH; k++) begin
            diff_now[k] = (x[k*WIDTH +: WIDTH] != voted);
            if (!diff_now[k]) begin
                cnt_nxt[k] = '0;
            end else if (cnt[k] == LIMIT) begin
                cnt_nxt[k] = LIMIT;
            end else begin
                cnt_nxt[k] = cnt[k] + 1'b1;
            end
            if (cnt_nxt[k] == LIMIT) begin
                faulty_nxt[k] = 1'b1;
            end
        end
    end

    // Idle cycles leave counters untouched so gaps never break a run.
    always_ff @(posedge clk) begin
        if (rst) begin
            y         <= '0;
            y_valid   <= 1'b0;
            disagree  <= '0;
            faulty    <= '0;
            any_fault <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            y_valid <= valid_in;
            if (valid_in) begin
                y        <= voted;
                disagree <= diff_now;
            end
            if (clear_faults) begin
                faulty    <= '0;
                any_fault <= 1'b0;
                for (int k = 0; k < N_CH; k++) begin
                    cnt[k] <= '0;
                end
            end else if (valid_in) begin
                faulty    <= faulty_nxt;
                any_fault <= |faulty_nxt;
                for (int k = 0; k < N_CH; k++) begin
                    cnt[k] <= cnt_nxt[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_majority_vote_sync.sv
// Directed bench for majority_vote_sync: 8-bit table-driven sequence plus 1-bit exhaustive vote.
module tb_majority_vote_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] x;
    logic        valid_in;
    logic        clear_faults;
    logic [7:0]  y;
    logic        y_valid;
    logic [2:0]  disagree;
    logic [2:0]  faulty;
    logic        any_fault;

    logic [2:0]  x1;
    logic        valid1;
    logic        clear1;
    logic [0:0]  y1;
    logic        y_valid1;
    logic [2:0]  disagree1;
    logic [2:0]  faulty1;
    logic        any_fault1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    majority_vote_sync #(.N_CH(3), .WIDTH(8), .FAULT_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .x(x), .valid_in(valid_in), .clear_faults(clear_faults),
        .y(y), .y_valid(y_valid), .disagree(disagree), .faulty(faulty), .any_fault(any_fault)
    );

    majority_vote_sync #(.N_CH(3), .WIDTH(1), .FAULT_LIMIT(4)) dut1 (
        .clk(clk), .rst(rst), .x(x1), .valid_in(valid1), .clear_faults(clear1),
        .y(y1), .y_valid(y_valid1), .disagree(disagree1), .faulty(faulty1), .any_fault(any_fault1)
    );

    typedef struct {
        logic [23:0] x;
        logic        v;
        logic        c;
        logic [7:0]  y;
        logic        yv;
        logic [2:0]  dis;
        logic [2:0]  f;
        logic        a;
    } vec_t;

    vec_t tbl[$];

    localparam logic [23:0] A3  = 24'hA5A5A5;
    localparam logic [23:0] W2  = 24'h5AA5A5;
    localparam logic [23:0] W1  = 24'hA55AA5;
    localparam logic [23:0] MIX = 24'hF00FFF;
    localparam logic [23:0] IDL = 24'h000000;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [7:0] ey, input logic eyv,
                           input logic [2:0] edis, input logic [2:0] ef, input logic ea);
        chk({tag, ".y"}, idx, 32'(y), 32'(ey));
        chk({tag, ".y_valid"}, idx, 32'(y_valid), 32'(eyv));
        chk({tag, ".disagree"}, idx, 32'(disagree), 32'(edis));
        chk({tag, ".faulty"}, idx, 32'(faulty), 32'(ef));
        chk({tag, ".any_fault"}, idx, 32'(any_fault), 32'(ea));
    endtask

    task automatic add(input logic [23:0] vx, input logic v, input logic c, input logic [7:0] ey,
                       input logic eyv, input logic [2:0] edis, input logic [2:0] ef, input logic ea);
        vec_t e;
        e.x = vx; e.v = v; e.c = c; e.y = ey; e.yv = eyv; e.dis = edis; e.f = ef; e.a = ea;
        tbl.push_back(e);
    endtask

    task automatic step(input logic [23:0] vx, input logic v, input logic c, input logic r);
        x = vx; valid_in = v; clear_faults = c; rst = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  exp_y1_tab;
        logic [23:0] exp_d1_tab;

        rst = 1'b1; x = '0; valid_in = 1'b0; clear_faults = 1'b0;
        x1 = '0; valid1 = 1'b0; clear1 = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk_all("reset", 0, 8'h00, 1'b0, 3'b000, 3'b000, 1'b0);

        // agreement and hold
        add(A3,  1, 0, 8'hA5, 1, 3'b000, 3'b000, 0);
        add(IDL, 0, 0, 8'hA5, 0, 3'b000, 3'b000, 0);
        // bitwise mix: ch1 and ch2 disagree; four in a row fault both
        add(MIX, 1, 0, 8'hFF, 1, 3'b110, 3'b000, 0);
        add(MIX, 1, 0, 8'hFF, 1, 3'b110, 3'b000, 0);
        add(MIX, 1, 0, 8'hFF, 1, 3'b110, 3'b000, 0);
        add(MIX, 1, 0, 8'hFF, 1, 3'b110, 3'b110, 1);
        add(A3,  0, 1, 8'hFF, 0, 3'b110, 3'b000, 0);
        add(A3,  1, 0, 8'hA5, 1, 3'b000, 3'b000, 0);
        // fault build-up on ch2 with gaps and an agreeing sample in the middle
        add(W2,  1, 0, 8'hA5, 1, 3'b100, 3'b000, 0);
        add(IDL, 0, 0, 8'hA5, 0, 3'b100, 3'b000, 0);
        add(W2,  1, 0, 8'hA5, 1, 3'b100, 3'b000, 0);
        add(IDL, 0, 0, 8'hA5, 0, 3'b100, 3'b000, 0);
        add(W2,  1, 0, 8'hA5, 1, 3'b100, 3'b000, 0);
        add(IDL, 0, 0, 8'hA5, 0, 3'b100, 3'b000, 0);
        add(A3,  1, 0, 8'hA5, 1, 3'b000, 3'b000, 0);
        add(IDL, 0, 0, 8'hA5, 0, 3'b000, 3'b000, 0);
        add(W2,  1, 0, 8'hA5, 1, 3'b100, 3'b000, 0);
        add(IDL, 0, 0, 8'hA5, 0, 3'b100, 3'b000, 0);
        add(W2,  1, 0, 8'hA5, 1, 3'b100, 3'b000, 0);
        add(W2,  1, 0, 8'hA5, 1, 3'b100, 3'b000, 0);
        add(IDL, 0, 0, 8'hA5, 0, 3'b100, 3'b000, 0);
        add(W2,  1, 0, 8'hA5, 1, 3'b100, 3'b100, 1);
        add(IDL, 0, 0, 8'hA5, 0, 3'b100, 3'b100, 1);
        add(A3,  1, 0, 8'hA5, 1, 3'b000, 3'b100, 1);
        add(A3,  1, 0, 8'hA5, 1, 3'b000, 3'b100, 1);
        // clear wins over a simultaneous wrong sample; that sample is not counted
        add(W2,  1, 1, 8'hA5, 1, 3'b100, 3'b000, 0);
        add(W2,  1, 0, 8'hA5, 1, 3'b100, 3'b000, 0);
        add(W2,  1, 0, 8'hA5, 1, 3'b100, 3'b000, 0);
        add(W2,  1, 0, 8'hA5, 1, 3'b100, 3'b000, 0);
        add(W2,  1, 0, 8'hA5, 1, 3'b100, 3'b100, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].x, tbl[i].v, tbl[i].c, 1'b0);
            chk_all("tbl", i + 1, tbl[i].y, tbl[i].yv, tbl[i].dis, tbl[i].f, tbl[i].a);
        end

        // reset mid-run: rst beats valid and clear, and discards the partial run on ch1
        step(W1, 1, 0, 1'b0);
        step(W1, 1, 0, 1'b0);
        step(W1, 1, 0, 1'b0);
        chk_all("rst_pre", 1, 8'hA5, 1'b1, 3'b010, 3'b100, 1'b1);
        step(W1, 1, 1, 1'b1);
        chk_all("rst_mid", 2, 8'h00, 1'b0, 3'b000, 3'b000, 1'b0);
        step(W1, 1, 0, 1'b0);
        chk_all("rst_post", 3, 8'hA5, 1'b1, 3'b010, 3'b000, 1'b0);
        step(W1, 1, 0, 1'b0);
        step(W1, 1, 0, 1'b0);
        chk_all("rst_post", 4, 8'hA5, 1'b1, 3'b010, 3'b000, 1'b0);
        step(W1, 1, 0, 1'b0);
        chk_all("rst_post", 5, 8'hA5, 1'b1, 3'b010, 3'b010, 1'b1);
        step(IDL, 0, 0, 1'b0);

        // exhaustive 1-bit vote over {x2,x1,x0}
        exp_y1_tab = 8'b1110_1000;
        exp_d1_tab = {3'b000, 3'b001, 3'b010, 3'b100, 3'b100, 3'b010, 3'b001, 3'b000};
        for (int v = 0; v < 8; v++) begin
            x1 = 3'(v); valid1 = 1'b1;
            @(posedge clk); #1;
            chk("w1.y", v, 32'(y1), 32'(exp_y1_tab[v]));
            chk("w1.disagree", v, 32'(disagree1), 32'(exp_d1_tab[v*3 +: 3]));
            chk("w1.y_valid", v, 32'(y_valid1), 32'd1);
        end
        valid1 = 1'b0;
        @(posedge clk); #1;
        chk("w1.y_valid_idle", 8, 32'(y_valid1), 32'd0);
        chk("w1.y_hold", 8, 32'(y1), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
